// File: rtl/bsram_arb_pkg.sv
// Shared types and defaults for the data-memory read-port arbiter.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 10
`endif

package bsram_arb_pkg;

  localparam int unsigned CpuMaxRunDefault = 4;

  typedef enum logic [1:0] {StIdle, StBurst, StDrain, StDone} arb_state_e;

  typedef enum logic [1:0] {TagNone, TagCpu, TagVid} rd_tag_e;

endpackage

// File: rtl/bsram_arbiter_if.sv
// CPU load/store, video burst and bsram port signals of the arbiter.
interface bsram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = `DATA_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  cpu_rd_req;
  logic [ADDR_WIDTH-1:0] cpu_rd_addr;
  logic                  cpu_rd_gnt;
  logic                  cpu_rd_valid;
  logic [15:0]           cpu_rd_data;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr;
  logic [15:0]           cpu_wr_data;
  logic                  vid_start;
  logic [ADDR_WIDTH-1:0] vid_base;
  logic [LEN_WIDTH-1:0]  vid_len;
  logic                  vid_busy;
  logic                  vid_valid;
  logic [15:0]           vid_data;
  logic                  vid_ready;
  logic                  vid_done;
  logic [ADDR_WIDTH-1:0] mem_dout_addr;
  logic [15:0]           mem_dout;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_din_addr;
  logic [15:0]           mem_din;

  modport slave (
    input  cpu_rd_req, cpu_rd_addr, cpu_we, cpu_wr_addr, cpu_wr_data,
    input  vid_start, vid_base, vid_len, vid_ready, mem_dout,
    output cpu_rd_gnt, cpu_rd_valid, cpu_rd_data, vid_busy, vid_valid, vid_data, vid_done,
    output mem_dout_addr, mem_we, mem_din_addr, mem_din
  );

  modport master (
    output cpu_rd_req, cpu_rd_addr, cpu_we, cpu_wr_addr, cpu_wr_data,
    output vid_start, vid_base, vid_len, vid_ready, mem_dout,
    input  cpu_rd_gnt, cpu_rd_valid, cpu_rd_data, vid_busy, vid_valid, vid_data, vid_done,
    input  mem_dout_addr, mem_we, mem_din_addr, mem_din
  );
endinterface

// File: rtl/fifo2.sv
// Two-entry 16-bit fall-through FIFO; a push into an empty FIFO is visible
// at the head in the same cycle.
module fifo2 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic        valid,
  output logic [15:0] data,
  output logic [1:0]  count
);
  logic [15:0] mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        empty, store, take;

  assign empty = (count_q == 2'd0);
  assign valid = !empty || push;
  assign data  = !empty ? mem_q[rd_ptr_q] : (push ? push_data : 16'h0000);
  assign count = count_q;
  assign take  = pop && !empty;
  // A word pushed and popped while empty bypasses storage entirely.
  assign store = push && !(empty && pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= 16'h0000;
      mem_q[1] <= 16'h0000;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (take) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + {1'b0, store} - {1'b0, take};
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: rtl/bsram_arbiter.sv
// Shares the bsram read port between CPU loads and video bursts; CPU writes
// pass straight through to the write port.
module bsram_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = `DATA_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned CPU_MAX_RUN = CpuMaxRunDefault
) (
  input logic            clk,
  input logic            resetn,
  bsram_arbiter_if.slave bus
);
  localparam int unsigned RunW = $clog2(CPU_MAX_RUN + 1);

  arb_state_e            state_q, state_d;
  rd_tag_e               tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [RunW-1:0]       run_q, run_d;
  logic                  vid_elig, cpu_gnt, vid_gnt;
  logic                  fifo_push, fifo_pop, fifo_valid;
  logic [15:0]           fifo_data;
  logic [1:0]            fifo_count;

  assign fifo_push = (tag_q == TagVid);
  // In-flight video reads count against buffer space so the FIFO never overflows.
  assign vid_elig  = (state_q == StBurst) && (rem_q != '0) &&
                     (({1'b0, fifo_count} + {2'b00, fifo_push}) < 3'd2);
  assign cpu_gnt   = bus.cpu_rd_req && (!vid_elig || (run_q < RunW'(CPU_MAX_RUN)));
  assign vid_gnt   = vid_elig && !cpu_gnt;
  assign fifo_pop  = fifo_valid && bus.vid_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    run_d     = run_q;
    rd_addr_d = rd_addr_q;
    tag_d     = TagNone;

    if (cpu_gnt) begin
      tag_d     = TagCpu;
      rd_addr_d = bus.cpu_rd_addr;
    end else if (vid_gnt) begin
      tag_d     = TagVid;
      rd_addr_d = addr_q;
      addr_d    = addr_q + ADDR_WIDTH'(1);
      rem_d     = rem_q - LEN_WIDTH'(1);
    end

    if (!vid_elig || vid_gnt) begin
      run_d = '0;
    end else if (cpu_gnt && (run_q < RunW'(CPU_MAX_RUN))) begin
      run_d = run_q + RunW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.vid_start) begin
          addr_d  = bus.vid_base;
          rem_d   = bus.vid_len;
          state_d = (bus.vid_len == '0) ? StDone : StBurst;
        end
      end
      StBurst: if (rem_q == '0) state_d = StDrain;
      StDrain: if ((fifo_count == 2'd0) && (tag_q != TagVid)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      tag_q     <= TagNone;
      addr_q    <= '0;
      rem_q     <= '0;
      run_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      run_q     <= run_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  fifo2 u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (bus.mem_dout),
    .pop       (fifo_pop),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .count     (fifo_count)
  );

  assign bus.mem_dout_addr = rd_addr_d;
  assign bus.cpu_rd_gnt    = cpu_gnt;
  assign bus.cpu_rd_valid  = (tag_q == TagCpu);
  assign bus.cpu_rd_data   = (tag_q == TagCpu) ? bus.mem_dout : 16'h0000;
  assign bus.vid_busy      = (state_q != StIdle);
  assign bus.vid_done      = (state_q == StDone);
  assign bus.vid_valid     = fifo_valid;
  assign bus.vid_data      = fifo_data;
  assign bus.mem_we        = bus.cpu_we;
  assign bus.mem_din_addr  = bus.cpu_wr_addr;
  assign bus.mem_din       = bus.cpu_wr_data;

endmodule
